// File: rtl/player_move_ctrl.sv
// ---------------------------------------------------------------------------------------------
// player_move_ctrl
//
// Per-frame motion controller for the player sprite. Once per video frame it applies horizontal
// walking from the left/right keys and runs a small jump/fall state machine driven by the jump
// key and the collision flag. Produces the top-left corner of the player draw object.
//
// Position and vertical velocity are kept as signed 32-bit fixed point with 6 fraction bits;
// the pixel outputs are taken straight from the position registers (pos >>> 6, low 11 bits).
//
// Ports:
//   clk           in   1   VGA clock
//   resetN        in   1   asynchronous, active-low reset
//   startOfFrame  in   1   one-cycle pulse per frame; positions update on the edge ending it
//   leftKey       in   1   walk left (level)
//   rightKey      in   1   walk right (level)
//   jumpKey       in   1   jump request (level)
//   collision     in   1   player/obstacle overlap pixel, may pulse in any cycle
//   topLeftX      out  11  player X, integer pixels
//   topLeftY      out  11  player Y, integer pixels (wraps when above the screen)
//   state         out  2   0=GROUND 1=JUMP 2=FALL
//   onGround      out  1   state == GROUND
//
// Build option:
//   PLAYER_WRAP_X_EN  when defined, walking off either horizontal edge wraps to the other edge
//                     instead of clamping. Vertical behaviour is the same in both builds.
// ---------------------------------------------------------------------------------------------
module player_move_ctrl #(
    parameter int INIT_X   = 280,   // reset X position, pixels
    parameter int FLOOR_Y  = 400,   // floor line, pixels
    parameter int OBJ_W    = 32,    // player width, pixels
    parameter int OBJ_H    = 32,    // player height, pixels
    parameter int SCREEN_W = 640,   // visible width, pixels
    parameter int SPEED_X  = 128,   // walk speed, 1/64 px per frame
    parameter int JUMP_VY  = -384,  // initial jump velocity, 1/64 px per frame
    parameter int GRAVITY  = 16,    // vy increment per frame, 1/64 px
    parameter int MAX_VY   = 640    // fall speed saturation, 1/64 px per frame
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        leftKey,
    input  logic        rightKey,
    input  logic        jumpKey,
    input  logic        collision,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [1:0]  state,
    output logic        onGround
);

    // Fixed-point limits (6 fraction bits)
    localparam int XMaxFx   = (SCREEN_W - OBJ_W) * 64;
    localparam int FloorFx  = (FLOOR_Y - OBJ_H) * 64;
    localparam int InitXFx  = INIT_X * 64;

    typedef enum logic [1:0] {
        StGround = 2'd0,
        StJump   = 2'd1,
        StFall   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic signed [31:0] pos_x_q, pos_x_d;
    logic signed [31:0] pos_y_q, pos_y_d;
    logic signed [31:0] vy_q, vy_d;
    logic               coll_q, coll_d;

    logic               coll_seen;
    logic signed [31:0] x_step;
    logic signed [31:0] x_next;
    logic signed [31:0] y_sum;
    logic signed [31:0] vy_sum;
    logic signed [31:0] vy_sat;

    // ---------------------------------------------------------------------------------------
    // Collision latch: any collision cycle since the last update is remembered. A collision in
    // the pulse cycle itself is folded in through coll_seen and the latch is cleared on that
    // same edge, so it counts for exactly one update.
    // ---------------------------------------------------------------------------------------
    assign coll_seen = coll_q | collision;
    assign coll_d    = startOfFrame ? 1'b0 : coll_seen;

    // ---------------------------------------------------------------------------------------
    // Horizontal step and edge handling
    // ---------------------------------------------------------------------------------------
    always_comb begin
        x_step = pos_x_q;
        if (leftKey && !rightKey) begin
            x_step = pos_x_q - SPEED_X;
        end else if (rightKey && !leftKey) begin
            x_step = pos_x_q + SPEED_X;
        end
    end

`ifdef PLAYER_WRAP_X_EN
    always_comb begin
        x_next = x_step;
        if (x_step < 0) begin
            x_next = XMaxFx;
        end else if (x_step > XMaxFx) begin
            x_next = '0;
        end
    end
`else
    always_comb begin
        x_next = x_step;
        if (x_step < 0) begin
            x_next = '0;
        end else if (x_step > XMaxFx) begin
            x_next = XMaxFx;
        end
    end
`endif

    // ---------------------------------------------------------------------------------------
    // Vertical arithmetic shared by the JUMP and FALL states
    // ---------------------------------------------------------------------------------------
    assign y_sum  = pos_y_q + vy_q;
    assign vy_sum = vy_q + GRAVITY;
    assign vy_sat = (vy_sum > MAX_VY) ? MAX_VY : vy_sum;

    // ---------------------------------------------------------------------------------------
    // Next-state logic; everything holds unless this is the pulse cycle.
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        vy_d    = vy_q;

        if (startOfFrame) begin
            pos_x_d = x_next;

            case (state_q)
                StGround: begin
                    // Take-off frame: velocity is loaded but Y does not move yet
                    if (jumpKey) begin
                        vy_d    = JUMP_VY;
                        state_d = StJump;
                    end else begin
                        vy_d = '0;
                    end
                end

                StJump: begin
                    if (coll_seen) begin
                        // Head bump: stop rising, start falling from where we are
                        vy_d    = '0;
                        state_d = StFall;
                    end else begin
                        pos_y_d = y_sum;
                        vy_d    = vy_sum;
                        if (vy_sum >= 0) begin
                            state_d = StFall;
                        end
                    end
                end

                StFall: begin
                    if (y_sum >= FloorFx) begin
                        // Never go below the floor; snap onto it
                        pos_y_d = FloorFx;
                        vy_d    = '0;
                        state_d = StGround;
                    end else if (coll_seen && (vy_q > 0)) begin
                        // Landed on an obstacle: stay at the current height
                        vy_d    = '0;
                        state_d = StGround;
                    end else begin
                        pos_y_d = y_sum;
                        vy_d    = vy_sat;
                    end
                end

                default: begin
                    state_d = StGround;
                    vy_d    = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StGround;
            pos_x_q <= InitXFx;
            pos_y_q <= FloorFx;
            vy_q    <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            vy_q    <= vy_d;
            coll_q  <= coll_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Outputs come directly from the registers, so reset is visible without a clock edge.
    // ---------------------------------------------------------------------------------------
    assign topLeftX = pos_x_q[16:6];
    assign topLeftY = pos_y_q[16:6];
    assign state    = state_q;
    assign onGround = (state_q == StGround);

endmodule
